// File: rtl/die_select_encoder_pkg.sv
// Shared FSM state type and default parameter values for the die-select encoder.
package dice_pkg;

    localparam int DEF_NUM_BUTTONS     = 7;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_e;

endpackage

// File: rtl/die_select_encoder_debounce_bit.sv
// One button bit: 2-flop synchroniser, stability counter, debounced flop.
// Latency: 2 sync + DEBOUNCE_CYCLES cycles from raw edge to o_deb; no backpressure.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_deb
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;

    // A bit that returns to the debounced level clears the count, so only an
    // unbroken run of the new level can flip the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_deb  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/die_select_encoder.sv
// Debounces NUM_BUTTONS raw buttons and latches the index of a single accepted press.
// Latency: 2 + DEBOUNCE_CYCLES + 1 cycles raw edge to sel_valid; no backpressure.
// DIE_SELECT_PRIORITY_EN: multi-button presses take the lowest index instead of flagging multi_err.
module die_select_encoder
    import dice_pkg::*;
#(
    parameter int                NUM_BUTTONS     = DEF_NUM_BUTTONS,
    parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                SEL_W           = $clog2(NUM_BUTTONS + 1),
    parameter logic [SEL_W-1:0]  DEFAULT_SEL     = '1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [SEL_W-1:0]       die_sel,
    output logic                   sel_valid,
    output logic                   multi_err,
    output logic                   busy
);

    logic [NUM_BUTTONS-1:0] w_deb;
    logic [SEL_W-1:0]       w_low;
    logic                   w_enter;
    logic                   w_accept;
    logic                   w_err;
    state_e                 w_state_nxt;

    state_e                 r_state;
    logic [SEL_W-1:0]       r_sel;
    logic                   r_vld;
    logic                   r_err;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .i_raw (buttons[g]),
            .o_deb (w_deb[g])
        );
    end

    always_comb begin
        w_low = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (w_deb[i]) w_low = SEL_W'(i);
        end
    end

`ifndef DIE_SELECT_PRIORITY_EN
    logic w_multi;
    assign w_multi = |(w_deb & (w_deb - NUM_BUTTONS'(1)));
`endif

    // Only the IDLE->HELD edge can accept; HELD waits for a full release.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_deb) begin
                    w_state_nxt = HELD;
                    w_enter     = 1'b1;
                end
            end
            HELD: begin
                if (!(|w_deb)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
`ifdef DIE_SELECT_PRIORITY_EN
        w_accept = w_enter;
`else
        w_accept = w_enter && !w_multi;
        w_err    = w_enter && w_multi;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= DEFAULT_SEL;
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vld   <= w_accept;
            r_err   <= w_err;
            if (w_accept) r_sel <= w_low;
        end
    end

    assign die_sel   = r_sel;
    assign sel_valid = r_vld;
    assign multi_err = r_err;
    assign busy      = (r_state == HELD);

endmodule

// File: tb/tb_die_select_encoder.sv
// Directed scenarios plus random presses, every cycle compared to a behavioural model.
module tb_die_select_encoder;

    localparam int NB = 7;
    localparam int DC = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] buttons;
    logic [SW-1:0] die_sel;
    logic          sel_valid;
    logic          multi_err;
    logic          busy;

    always #5 clk = ~clk;

    die_select_encoder #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buttons   (buttons),
        .die_sel   (die_sel),
        .sel_valid (sel_valid),
        .multi_err (multi_err),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: synchronised samples arrive two edges late; a debounced
    // bit adopts a level once the last DC synchronised samples all hold it.
    logic [NB-1:0] m_meta, m_sync, m_deb;
    logic [NB-1:0] sync_hist[$];
    bit            m_held, m_vld, m_err;
    logic [SW-1:0] m_sel;

    task automatic model_reset();
        m_meta = '0; m_sync = '0; m_deb = '0;
        sync_hist.delete();
        m_held = 0; m_vld = 0; m_err = 0;
        m_sel  = '1;
    endtask

    task automatic model_update(input logic [NB-1:0] b);
        int  n1;
        int  idx;
        bit  found;
        bit  all_new;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_vld = 0;
        m_err = 0;
        if (!m_held) begin
            if (m_deb != 0) begin
                m_held = 1;
                n1 = $countones(m_deb);
                found = 0;
                idx = 0;
                for (int i = 0; i < NB; i++)
                    if (m_deb[i] && !found) begin idx = i; found = 1; end
`ifdef DIE_SELECT_PRIORITY_EN
                m_sel = SW'(idx);
                m_vld = 1;
`else
                if (n1 == 1) begin
                    m_sel = SW'(idx);
                    m_vld = 1;
                end else begin
                    m_err = 1;
                end
`endif
            end
        end else if (m_deb == 0) begin
            m_held = 0;
        end
        if (sync_hist.size() >= DC) begin
            for (int i = 0; i < NB; i++) begin
                all_new = 1;
                for (int k = sync_hist.size() - DC; k < sync_hist.size(); k++)
                    if (sync_hist[k][i] == m_deb[i]) all_new = 0;
                if (all_new) m_deb[i] = ~m_deb[i];
            end
        end
        m_sync = m_meta;
        m_meta = b;
        sync_hist.push_back(m_sync);
        if (sync_hist.size() > DC) void'(sync_hist.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        model_update(buttons);
        #1;
        vld_cnt += int'(sel_valid);
        err_cnt += int'(multi_err);
        check("die_sel",   32'(die_sel),   32'(m_sel));
        check("sel_valid", 32'(sel_valid), 32'(m_vld));
        check("multi_err", 32'(multi_err), 32'(m_err));
        check("busy",      32'(busy),      32'(m_held));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cycles_to_valid(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sel_valid && n < max);
    endtask

    task automatic cycles_to_idle(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < max);
    endtask

    initial begin
        int n;
        int v0;
        int e0;
        logic [NB-1:0] pat;
        model_reset();
        rst_n   = 1'b0;
        buttons = '0;
        steps(3);
        rst_n = 1'b1;
        steps(5);
        check("rst_die_sel", 32'(die_sel), 32'h7);
        check("rst_sel_valid", 32'(sel_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // single press: latency and release timing
        buttons = 7'b0000100;
        cycles_to_valid(30, n);
        check("press_latency", 32'(n), 32'd7);
        check("press_die_sel", 32'(die_sel), 32'd2);
        steps(20 - n);
        buttons = '0;
        cycles_to_idle(30, n);
        check("release_latency", 32'(n), 32'd7);
        steps(3);

        // bouncing bit never settles long enough
        v0 = vld_cnt;
        for (int i = 0; i < 15; i++) begin
            buttons[3] = ~buttons[3];
            steps(2);
        end
        buttons = '0;
        steps(10);
        check("bounce_pulses", 32'(vld_cnt - v0), 32'd0);
        check("bounce_die_sel", 32'(die_sel), 32'd2);

        // two buttons together
        v0 = vld_cnt;
        e0 = err_cnt;
        buttons = 7'b0100010;
        steps(12);
`ifdef DIE_SELECT_PRIORITY_EN
        check("multi_die_sel", 32'(die_sel), 32'd1);
        check("multi_pulses", 32'(vld_cnt - v0), 32'd1);
        check("multi_err_cnt", 32'(err_cnt - e0), 32'd0);
`else
        check("multi_die_sel", 32'(die_sel), 32'd2);
        check("multi_pulses", 32'(vld_cnt - v0), 32'd0);
        check("multi_err_cnt", 32'(err_cnt - e0), 32'd1);
`endif
        check("multi_busy", 32'(busy), 32'd1);
        buttons = '0;
        steps(10);

        // extra press while held is ignored
        v0 = vld_cnt;
        buttons = 7'b0000001;
        steps(10);
        buttons = 7'b1000001;
        steps(10);
        check("held_die_sel", 32'(die_sel), 32'd0);
        check("held_pulses", 32'(vld_cnt - v0), 32'd1);
        buttons = '0;
        steps(10);
        buttons = 7'b1000000;
        steps(10);
        check("after_release_sel", 32'(die_sel), 32'd6);
        buttons = '0;
        steps(10);

        // reset mid-press, button still held afterwards
        buttons = 7'b0010000;
        steps(10);
        rst_n = 1'b0;
        #1;
        check("async_rst_die_sel", 32'(die_sel), 32'h7);
        steps(3);
        check("in_rst_die_sel", 32'(die_sel), 32'h7);
        check("in_rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        cycles_to_valid(30, n);
        check("post_rst_latency", 32'(n), 32'd7);
        check("post_rst_die_sel", 32'(die_sel), 32'd4);
        buttons = '0;
        steps(10);

        // random presses, releases and bounces
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: pat = NB'(1) << $urandom_range(0, NB - 1);
                6, 7:             pat = '0;
                default:          pat = NB'($urandom);
            endcase
            buttons = pat;
            steps($urandom_range(1, 10));
        end
        buttons = '0;
        steps(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
